parity_serializer: RTL and testbench

Serial transmit stage that consumes a 4-bit data nibble, computes its parity bit, and shifts out a framed bit stream on a single line. Frame order: start, d0..d3 (LSB first), parity, stop. Sits directly downstream of the 4-bit parity generator and reuses it for parity computation. Upstream producers hand nibbles in with a valid/ready handshake; the line output drives an off-block serial link.

---
 rtl/parity_serializer_pkg.sv | 23 ++
 rtl/parity_serializer_parity.sv | 18 +
 rtl/parity_serializer.sv | 124 ++++++++++++
 tb/tb_parity_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_serializer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// parity_serializer_pkg : FSM encodings, frame length and counter sizing
// Revision 1.0
// ============================================================================
package parity_serializer_pkg;

  localparam logic [2:0] PS_IDLE   = 3'd0;
  localparam logic [2:0] PS_START  = 3'd1;
  localparam logic [2:0] PS_DATA   = 3'd2;
  localparam logic [2:0] PS_PARITY = 3'd3;
  localparam logic [2:0] PS_STOP   = 3'd4;

  localparam int PS_FRAME_BITS = 7;

  // A divider of 1 still needs a 1-bit counter to keep the vector legal.
  function automatic int ps_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/parity_serializer_parity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// parity : combinational 4-bit parity generator (even/odd parity bit)
// Revision 1.0
// ============================================================================
module parity (
  input  logic [3:0] x,
  output logic       odd,
  output logic       even
);

  // Each output is the bit that, appended to x, yields that parity sense.
  assign even = ^x;
  assign odd  = ~(^x);

endmodule
`default_nettype wire

// File: rtl/parity_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// parity_serializer : framed serial TX (start, d0..d3, parity, stop)
// Revision 1.0
// ============================================================================
module parity_serializer
  import parity_serializer_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 4,
  parameter bit          PAR_EVEN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd,
  output logic       busy
);

  localparam int            CW       = ps_cnt_width(int'(BAUD_DIV));
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [1:0]    bit_idx;
  logic [3:0]    data_lat;
  logic          par_lat;
  logic          par_odd;
  logic          par_even;
  logic          par_bit;
  logic          bit_last;

  parity u_parity (
    .x    (data),
    .odd  (par_odd),
    .even (par_even)
  );

  assign par_bit  = PAR_EVEN ? par_even : par_odd;
  assign bit_last = (baud_cnt == CNT_LAST);
  assign ready    = (state == PS_IDLE) && !rst;

  // txd is updated together with the state so it is already correct in the
  // first cycle of each bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PS_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_lat <= '0;
      par_lat  <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        PS_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (valid && ready) begin
            data_lat <= data;
            par_lat  <= par_bit;
            state    <= PS_START;
            txd      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        PS_START: begin
          if (bit_last) begin
            baud_cnt <= '0;
            bit_idx  <= 2'd0;
            state    <= PS_DATA;
            txd      <= data_lat[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        PS_DATA: begin
          if (bit_last) begin
            baud_cnt <= '0;
            if (bit_idx == 2'd3) begin
              state <= PS_PARITY;
              txd   <= par_lat;
            end else begin
              bit_idx <= bit_idx + 2'd1;
              txd     <= data_lat[bit_idx + 2'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        PS_PARITY: begin
          if (bit_last) begin
            baud_cnt <= '0;
            state    <= PS_STOP;
            txd      <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        PS_STOP: begin
          if (bit_last) begin
            baud_cnt <= '0;
            state    <= PS_IDLE;
            txd      <= 1'b1;
            busy     <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state    <= PS_IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          txd      <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_parity_serializer : directed vector bench, four parameter sets in parallel
// Revision 1.0
// ============================================================================
module tb_parity_serializer;
  import parity_serializer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld [4];
  logic [3:0] dat [4];
  logic       rdy [4];
  logic       tx  [4];
  logic       bsy [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parity_serializer #(.BAUD_DIV(4), .PAR_EVEN(1'b1)) u_b4_even (
    .clk(clk), .rst(rst), .data(dat[0]), .valid(vld[0]),
    .ready(rdy[0]), .txd(tx[0]), .busy(bsy[0]));
  parity_serializer #(.BAUD_DIV(4), .PAR_EVEN(1'b0)) u_b4_odd (
    .clk(clk), .rst(rst), .data(dat[1]), .valid(vld[1]),
    .ready(rdy[1]), .txd(tx[1]), .busy(bsy[1]));
  parity_serializer #(.BAUD_DIV(1), .PAR_EVEN(1'b1)) u_b1_even (
    .clk(clk), .rst(rst), .data(dat[2]), .valid(vld[2]),
    .ready(rdy[2]), .txd(tx[2]), .busy(bsy[2]));
  parity_serializer #(.BAUD_DIV(1), .PAR_EVEN(1'b0)) u_b1_odd (
    .clk(clk), .rst(rst), .data(dat[3]), .valid(vld[3]),
    .ready(rdy[3]), .txd(tx[3]), .busy(bsy[3]));

  // Frame vectors are bit-indexed in transmit order: [0]=start ... [6]=stop.
  typedef struct {
    int         inst;
    logic [3:0] d;
    logic [6:0] frame;
    string      name;
  } vec_t;

  vec_t vecs [6];

  function automatic int baud_of(input int i);
    return (i < 2) ? 4 : 1;
  endfunction

  task automatic check(input bit ok, input string name, input int got, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Sends one nibble and samples the whole frame; disturbs valid/data mid-frame.
  task automatic send_frame(input int i, input logic [3:0] d, input logic [6:0] exp,
                            input string name, output logic [6:0] got);
    int b_div;
    bit bad;
    b_div = baud_of(i);
    got   = '0;
    bad   = 1'b0;
    @(negedge clk);
    check(rdy[i] === 1'b1, {name, " ready before"}, int'(rdy[i]), 1);
    vld[i] = 1'b1;
    dat[i] = d;
    @(posedge clk);
    #1;
    vld[i] = 1'b0;
    dat[i] = ~d;
    for (int n = 0; n < 7 * b_div; n++) begin
      @(negedge clk);
      if (n % b_div == 0) got[n / b_div] = tx[i];
      else if (tx[i] !== got[n / b_div]) bad = 1'b1;
      if (bsy[i] !== 1'b1 || rdy[i] !== 1'b0) bad = 1'b1;
      vld[i] = (n < 7 * b_div - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      dat[i] = 4'($urandom);
    end
    check(!bad && got === exp, {name, " frame"}, int'({bad, got}), int'(exp));
    @(negedge clk);
    check(rdy[i] === 1'b1 && tx[i] === 1'b1 && bsy[i] === 1'b0, {name, " idle after"},
          int'({rdy[i], tx[i], bsy[i]}), 3'b110);
  endtask

  initial begin
    logic [6:0] got;
    logic [6:0] got1;
    logic [6:0] got2;
    logic       exp_par;
    bit         idle_ok;
    bit         start_ok;
    bit         quiet;

    vecs[0] = '{0, 4'b1011, 7'b1110110, "b4e_1011"};
    vecs[1] = '{1, 4'b0000, 7'b1100000, "b4o_0000"};
    vecs[2] = '{1, 4'b0101, 7'b1101010, "b4o_0101"};
    vecs[3] = '{0, 4'b0111, 7'b1101110, "b4e_0111"};
    vecs[4] = '{1, 4'b1110, 7'b1011100, "b4o_1110"};
    vecs[5] = '{0, 4'b1000, 7'b1110000, "b4e_1000"};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      dat[i] = 4'h0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check(tx[i] === 1'b1 && bsy[i] === 1'b0 && rdy[i] === 1'b0, "reset state",
            int'({rdy[i], tx[i], bsy[i]}), 3'b010);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check(rdy[i] === 1'b1, "ready after reset", int'(rdy[i]), 1);

    for (int v = 0; v < 6; v++)
      send_frame(vecs[v].inst, vecs[v].d, vecs[v].frame, vecs[v].name, got);

    // Back-to-back: valid held, data 3 then C; second start 29 cycles after first.
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 4'h3;
    @(posedge clk);
    #1;
    dat[0]   = 4'hC;
    got1     = '0;
    got2     = '0;
    idle_ok  = 1'b0;
    start_ok = 1'b0;
    for (int n = 1; n <= 57; n++) begin
      @(negedge clk);
      if (n <= 28) begin
        if ((n - 1) % 4 == 0) got1[(n - 1) / 4] = tx[0];
      end else if (n == 29) begin
        idle_ok = (tx[0] === 1'b1 && bsy[0] === 1'b0 && rdy[0] === 1'b1);
      end else begin
        if ((n - 30) % 4 == 0) got2[(n - 30) / 4] = tx[0];
        if (n == 30) start_ok = (tx[0] === 1'b0 && bsy[0] === 1'b1);
      end
      if (n == 57) vld[0] = 1'b0;
    end
    check(got1 === 7'b1000110, "b2b frame1", int'(got1), 7'b1000110);
    check(idle_ok, "b2b single idle", int'(idle_ok), 1);
    check(start_ok, "b2b start at +29", int'(start_ok), 1);
    check(got2 === 7'b1011000, "b2b frame2", int'(got2), 7'b1011000);
    @(negedge clk);
    check(rdy[0] === 1'b1 && tx[0] === 1'b1 && bsy[0] === 1'b0, "b2b idle after",
          int'({rdy[0], tx[0], bsy[0]}), 3'b110);

    // Reset in cycle 10 of a frame (data F: cycle 10 carries d1 = 1).
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 4'hF;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (10) @(negedge clk);
    check(tx[0] === 1'b1 && bsy[0] === 1'b1, "pre-reset frame running",
          int'({tx[0], bsy[0]}), 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check(tx[0] === 1'b1 && bsy[0] === 1'b0 && rdy[0] === 1'b0, "mid-frame reset",
          int'({rdy[0], tx[0], bsy[0]}), 3'b010);
    rst = 1'b0;
    @(negedge clk);
    check(rdy[0] === 1'b1, "ready after reset release", int'(rdy[0]), 1);
    quiet = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (tx[0] !== 1'b1 || bsy[0] !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    check(quiet, "no residual bits", int'(quiet), 1);

    // BAUD_DIV=1: every nibble under both parity senses.
    for (int p = 0; p < 2; p++) begin
      for (int d = 0; d < 16; d++) begin
        logic [3:0] nib;
        nib     = 4'(d);
        exp_par = (p == 0) ? ^nib : ~(^nib);
        send_frame(2 + p, nib, {1'b1, exp_par, nib, 1'b0},
                   (p == 0) ? "b1e sweep" : "b1o sweep", got);
        check(got[5] === exp_par, "sweep parity bit", int'(got[5]), int'(exp_par));
      end
    end

    check(PS_FRAME_BITS == 7 && checks > 0, "frame length constant", PS_FRAME_BITS, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
